// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bundle between the crossbar master-side port and the SRAM responder.
// Single-bit responses: 0 = OKAY, 1 = decode error.
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI4-Lite word-addressed SRAM responder with programmable read/write latency.
// Optional SRAM_RAND_DELAY_EN adds LFSR-driven extra latency and ready stalls.
module axi_lite_sram #(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input logic       clk,
    input logic       reset,
    axi_lite_if.slave s
);
    localparam int              IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int              CW        = 5;
    localparam logic [32:0]     WIN_BYTES = 33'(4 * DEPTH_WORDS);
    localparam logic [CW-1:0]   RD_LOAD   = CW'(RD_LAT - 1);
    localparam logic [CW-1:0]   WR_LOAD   = CW'(WR_LAT - 1);

    function automatic logic f_in_range(input logic [31:0] addr);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, BASE};
        return !off[32] && (off < WIN_BYTES);
    endfunction

    function automatic logic [IW-1:0] f_index(input logic [31:0] addr);
        return IW'((addr - BASE) >> 2);
    endfunction

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_stall;
    logic [CW-1:0] w_rd_extra;
    logic [CW-1:0] w_wr_extra;

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_next;

    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Readies are registered, so the stall uses the value the LFSR holds next cycle.
    assign w_stall    = w_lfsr_next[7];
    assign w_rd_extra = {2'b00, r_lfsr[2:0]};
    assign w_wr_extra = {2'b00, r_lfsr[2:0]};
`else
    logic w_unused_seed;
    assign w_unused_seed = ^LFSR_SEED;
    assign w_stall       = 1'b0;
    assign w_rd_extra    = '0;
    assign w_wr_extra    = '0;
`endif

    // ---------------- read path ----------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rstate_t;

    rstate_t       r_rstate;
    rstate_t       w_rstate_next;
    logic [CW-1:0] r_rcnt;
    logic [CW-1:0] w_rcnt_next;
    logic [31:0]   r_araddr;
    logic [31:0]   r_rdata;
    logic          r_rresp;
    logic          r_arready;
    logic          r_rvalid;
    logic          w_ar_fire;
    logic          w_r_fire;
    logic          w_rd_load;
    logic          w_rd_in_range;
    logic [IW-1:0] w_rd_idx;

    assign w_ar_fire     = s.arvalid && r_arready;
    assign w_r_fire      = r_rvalid && s.rready;
    assign w_rd_in_range = f_in_range(r_araddr);
    assign w_rd_idx      = f_index(r_araddr);

    always_comb begin
        w_rstate_next = r_rstate;
        w_rcnt_next   = r_rcnt;
        w_rd_load     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_fire) begin
                    w_rstate_next = R_WAIT;
                    w_rcnt_next   = RD_LOAD + w_rd_extra;
                end
            end
            R_WAIT: begin
                if (r_rcnt == '0) begin
                    w_rd_load     = 1'b1;
                    w_rstate_next = R_RESP;
                end else begin
                    w_rcnt_next = r_rcnt - 1'b1;
                end
            end
            R_RESP: begin
                if (w_r_fire) begin
                    w_rstate_next = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= '0;
            r_araddr  <= '0;
            r_rdata   <= '0;
            r_rresp   <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_next;
            r_rcnt    <= w_rcnt_next;
            r_arready <= (w_rstate_next == R_IDLE) && !w_stall;
            r_rvalid  <= (w_rstate_next == R_RESP);
            if (w_ar_fire) begin
                r_araddr <= s.araddr;
            end
            // Same-edge write commit to this word is not visible: r_mem updates non-blocking.
            if (w_rd_load) begin
                r_rdata <= w_rd_in_range ? r_mem[w_rd_idx] : 32'h0;
                r_rresp <= !w_rd_in_range;
            end
        end
    end

    // ---------------- write path ----------------
    typedef enum logic [2:0] {
        W_IDLE,
        W_GOT_AW,
        W_GOT_W,
        W_WAIT,
        W_RESP
    } wstate_t;

    wstate_t       r_wstate;
    wstate_t       w_wstate_next;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] w_wcnt_next;
    logic [31:0]   r_awaddr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wmask;
    logic          r_bresp;
    logic          r_awready;
    logic          r_wready;
    logic          r_bvalid;
    logic          w_aw_fire;
    logic          w_w_fire;
    logic          w_b_fire;
    logic          w_commit;
    logic          w_wr_in_range;
    logic [IW-1:0] w_wr_idx;

    assign w_aw_fire     = s.awvalid && r_awready;
    assign w_w_fire      = s.wvalid && r_wready;
    assign w_b_fire      = r_bvalid && s.bready;
    assign w_wr_in_range = f_in_range(r_awaddr);
    assign w_wr_idx      = f_index(r_awaddr);

    always_comb begin
        w_wstate_next = r_wstate;
        w_wcnt_next   = r_wcnt;
        w_commit      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_fire && w_w_fire) begin
                    w_wstate_next = W_WAIT;
                    w_wcnt_next   = WR_LOAD + w_wr_extra;
                end else if (w_aw_fire) begin
                    w_wstate_next = W_GOT_AW;
                end else if (w_w_fire) begin
                    w_wstate_next = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_w_fire) begin
                    w_wstate_next = W_WAIT;
                    w_wcnt_next   = WR_LOAD + w_wr_extra;
                end
            end
            W_GOT_W: begin
                if (w_aw_fire) begin
                    w_wstate_next = W_WAIT;
                    w_wcnt_next   = WR_LOAD + w_wr_extra;
                end
            end
            W_WAIT: begin
                if (r_wcnt == '0) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end else begin
                    w_wcnt_next = r_wcnt - 1'b1;
                end
            end
            W_RESP: begin
                if (w_b_fire) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_wcnt    <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_bresp   <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_wcnt    <= w_wcnt_next;
            r_awready <= ((w_wstate_next == W_IDLE) || (w_wstate_next == W_GOT_W)) && !w_stall;
            r_wready  <= ((w_wstate_next == W_IDLE) || (w_wstate_next == W_GOT_AW)) && !w_stall;
            r_bvalid  <= (w_wstate_next == W_RESP);
            if (w_aw_fire) begin
                r_awaddr <= s.awaddr;
            end
            if (w_w_fire) begin
                r_wdata <= s.wdata;
                r_wmask <= s.wmask;
            end
            if (w_commit) begin
                r_bresp <= !w_wr_in_range;
            end
        end
    end

    // Storage is deliberately not reset; a reset aborts W_WAIT so w_commit stays low.
    always_ff @(posedge clk) begin
        if (w_commit && w_wr_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (r_wmask[k]) begin
                    r_mem[w_wr_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    assign s.arready = r_arready;
    assign s.rvalid  = r_rvalid;
    assign s.rdata   = r_rdata;
    assign s.rresp   = r_rresp;
    assign s.awready = r_awready;
    assign s.wready  = r_wready;
    assign s.bvalid  = r_bvalid;
    assign s.bresp   = r_bresp;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed plus randomized bench for axi_lite_sram against an array-based memory model.
module tb_axi_lite_sram;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 1024;
    localparam int          RD_LAT = 1;
    localparam int          WR_LAT = 3;
`ifdef SRAM_RAND_DELAY_EN
    localparam int SLACK  = 7;
    localparam int N_RAND = 1000;
`else
    localparam int SLACK  = 0;
    localparam int N_RAND = 300;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_lite_if bus();

    axi_lite_sram #(
        .BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s(bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        longint x, lo;
        x  = longint'({32'b0, a});
        lo = longint'({32'b0, BASE});
        return (x >= lo) && (x < lo + 4 * DEPTH);
    endfunction

    function automatic int ref_index(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] mask);
        logic [31:0] res;
        res = old;
        for (int k = 0; k < 4; k++)
            if (mask[k]) res[8*k +: 8] = nw[8*k +: 8];
        return res;
    endfunction

    // Called and returns on a negedge.
    task automatic do_read(input logic [31:0] addr, input int hold);
        logic [31:0] exp_d;
        logic        exp_r;
        int          n;
        exp_r = !ref_in_range(addr);
        exp_d = exp_r ? 32'h0 : model[ref_index(addr)];
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        check("ar_accept", bus.arready, 1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        check("rd_latency_ok", (n >= RD_LAT) && (n <= RD_LAT + SLACK), 1);
        check("rdata", bus.rdata, exp_d);
        check("rresp", bus.rresp, exp_r);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("r_hold_valid", bus.rvalid, 1);
            check("r_hold_data", bus.rdata, exp_d);
            check("r_hold_arready", bus.arready, 0);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("r_done", bus.rvalid, 0);
`ifndef SRAM_RAND_DELAY_EN
        check("ar_after_r", bus.arready, 1);
`endif
    endtask

    // mode 0: AW and W together; 1: AW first, W after gap; 2: W first, AW after gap.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input int mode, input int gap, input int bhold);
        int aw_at, w_at, step, n;
        bit aw_done, w_done, aw_f, w_f, side_chk;
        aw_at = (mode == 2) ? gap : 0;
        w_at  = (mode == 1) ? gap : 0;
        aw_done = 0; w_done = 0; side_chk = 0; step = 0;
        while (!(aw_done && w_done) && step < 200) begin
            if (!aw_done && step >= aw_at) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
            if (!w_done && step >= w_at) begin
                bus.wdata = data; bus.wmask = mask; bus.wvalid = 1'b1;
            end
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_f) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_f)  begin w_done = 1;  bus.wvalid  = 1'b0; end
`ifndef SRAM_RAND_DELAY_EN
            if (!side_chk && w_done && !aw_done) begin
                side_chk = 1;
                check("got_w_wready", bus.wready, 0);
                check("got_w_awready", bus.awready, 1);
            end
            if (!side_chk && aw_done && !w_done) begin
                side_chk = 1;
                check("got_aw_awready", bus.awready, 0);
                check("got_aw_wready", bus.wready, 1);
            end
`endif
            step++;
        end
        check("wr_accept", {30'b0, aw_done, w_done}, 32'd3);
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        check("wr_latency_ok", (n >= WR_LAT) && (n <= WR_LAT + SLACK), 1);
        check("bresp", bus.bresp, !ref_in_range(addr));
        for (int h = 0; h < bhold; h++) begin
            @(negedge clk);
            check("b_hold_valid", bus.bvalid, 1);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("b_done", bus.bvalid, 0);
        if (ref_in_range(addr))
            model[ref_index(addr)] = ref_merge(model[ref_index(addr)], data, mask);
    endtask

    initial begin
        logic [31:0] old6, a;
        int          n, idx;

        reset = 1'b1;
        bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wmask = '0; bus.wvalid = 0;
        bus.bready = 0;

        @(negedge clk);
        check("rst_arready", bus.arready, 0);
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_bresp", bus.bresp, 0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_arready_still_low", bus.arready, 0);
        @(negedge clk);
`ifndef SRAM_RAND_DELAY_EN
        check("rel_arready", bus.arready, 1);
        check("rel_awready", bus.awready, 1);
        check("rel_wready", bus.wready, 1);
`endif

        for (int i = 0; i < 32; i++)
            do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
        do_write(BASE + 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D, 4'hF, 0, 0, 0);

        do_read(32'h8000_0010, 0);
        do_read(32'h8000_0013, 0);
        do_read(BASE + 32'(4 * (DEPTH - 1)), 0);

        do_write(32'h8000_0008, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(32'h8000_0008, 32'hDEAD_BEEF, 4'b0101, 0, 0, 1);
        bus.araddr = 32'h8000_0008;
        do_read(32'h8000_0008, 0);
        check("masked_merge", model[2], 32'h11AD_33EF);

        do_write(32'h8000_000C, 32'h0BAD_F00D, 4'hF, 2, 3, 0);
        do_read(32'h8000_000C, 0);
        do_write(32'h8000_0014, 32'h1357_9BDF, 4'b1100, 1, 2, 2);
        do_read(32'h8000_0014, 0);

        do_read(32'hA000_0000, 0);
        do_read(BASE + 32'(4 * DEPTH), 0);
        do_read(BASE - 32'd4, 0);
        do_write(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(BASE - 32'd4, 32'hFFFF_FFFF, 4'hF, 1, 1, 0);
        do_read(BASE, 0);
        do_read(BASE + 32'(4 * (DEPTH - 1)), 0);

        do_read(32'h8000_0018, 10);

        old6 = model[6];
        bus.awaddr = BASE + 32'd24; bus.wdata = ~old6; bus.wmask = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        while (!(bus.awready === 1'b1 && bus.wready === 1'b1) && n < 64) begin
            @(negedge clk); n++;
        end
        check("ww_accept", {31'b0, bus.awready && bus.wready}, 1);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        reset = 1'b1;
        #1;
        check("ww_rst_bvalid", bus.bvalid, 0);
        check("ww_rst_awready", bus.awready, 0);
        check("ww_rst_wready", bus.wready, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ww_no_bvalid", bus.bvalid, 0);
        end
`ifndef SRAM_RAND_DELAY_EN
        check("ww_rel_awready", bus.awready, 1);
        check("ww_rel_wready", bus.wready, 1);
`endif
        do_read(BASE + 32'd24, 0);
        check("ww_word_kept", model[6], old6);

        for (int t = 0; t < N_RAND; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) + ($urandom & 32'hFFFC)
                                               : BASE - 32'(4 * $urandom_range(1, 255));
            end else begin
                idx = $urandom_range(0, 31);
                a   = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
